// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared geometry, address field widths and FSM state encoding for data_cache
package data_cache_pkg;
   localparam int NUM_SETS   = 8;
   localparam int IDX_W      = $clog2(NUM_SETS);
   localparam int BLOCK_W    = 128;
   localparam int MEM_ADDR_W = 28;
   localparam int TAG_W      = MEM_ADDR_W - IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2,
      ST_UPDATE    = 2'd3
   } state_t;
endpackage

// File: rtl/data_cache_line_array.sv
// rtl/data_cache_line_array.sv - valid/dirty/tag/data storage, one async read port, one write port
module data_cache_line_array
   import data_cache_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [IDX_W-1:0]   i_rd_idx,
   output logic               o_valid,
   output logic               o_dirty,
   output logic [TAG_W-1:0]   o_tag,
   output logic [BLOCK_W-1:0] o_data,
   input  logic [IDX_W-1:0]   i_wr_idx,
   input  logic               i_fill_en,
   input  logic [TAG_W-1:0]   i_fill_tag,
   input  logic [BLOCK_W-1:0] i_fill_data,
   input  logic               i_word_en,
   input  logic [1:0]         i_word_sel,
   input  logic [31:0]        i_word_data,
   input  logic [3:0]         i_word_strb
);
   logic [NUM_SETS-1:0] r_valid;
   logic [NUM_SETS-1:0] r_dirty;
   logic [TAG_W-1:0]    r_tag  [NUM_SETS];
   logic [BLOCK_W-1:0]  r_data [NUM_SETS];

   assign o_valid = r_valid[i_rd_idx];
   assign o_dirty = r_dirty[i_rd_idx];
   assign o_tag   = r_tag[i_rd_idx];
   assign o_data  = r_data[i_rd_idx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_en) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_dirty[i_wr_idx] <= 1'b0;
      end else if (i_word_en) begin
         r_dirty[i_wr_idx] <= 1'b1;
      end
   end

   // Tag and data are left uninitialised; the valid bits alone gate their use.
   always_ff @(posedge i_clk) begin
      if (i_fill_en) begin
         r_tag[i_wr_idx]  <= i_fill_tag;
         r_data[i_wr_idx] <= i_fill_data;
      end else if (i_word_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_word_strb[b])
               r_data[i_wr_idx][{i_word_sel, 5'd0} + 7'(b * 8) +: 8] <= i_word_data[b*8 +: 8];
         end
      end
   end
endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate L1 data cache
module data_cache
   import data_cache_pkg::*;
(
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [31:0]           ADDRESS,
   input  logic [31:0]           WRITEDATA,
   input  logic [3:0]            WSTRB,
   output logic [31:0]           READDATA,
   output logic                  BUSYWAIT,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0]    MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
);
   state_t                r_state;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [MEM_ADDR_W-1:0] r_mem_addr;
   logic [BLOCK_W-1:0]    r_mem_wdata;
   logic [MEM_ADDR_W-1:0] r_miss_addr;
   logic [BLOCK_W-1:0]    r_fill_data;

   logic [IDX_W-1:0]      w_idx;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_valid;
   logic                  w_dirty;
   logic [TAG_W-1:0]      w_line_tag;
   logic [BLOCK_W-1:0]    w_line_data;
   logic                  w_hit;
   logic                  w_access;
   logic                  w_fill_en;
   logic                  w_word_en;
   logic [IDX_W-1:0]      w_wr_idx;
   logic                  w_unused;

   assign w_idx    = ADDRESS[3+IDX_W:4];
   assign w_tag    = ADDRESS[31:4+IDX_W];
   assign w_hit    = w_valid && (w_line_tag == w_tag);
   assign w_access = READ ^ WRITE;
   assign w_unused = &{1'b0, ADDRESS[1:0]};

   assign BUSYWAIT      = w_access && !(r_state == ST_IDLE && w_hit);
   assign READDATA      = w_line_data[{ADDRESS[3:2], 5'd0} +: 32];
   assign MEM_READ      = r_mem_read;
   assign MEM_WRITE     = r_mem_write;
   assign MEM_ADDRESS   = r_mem_addr;
   assign MEM_WRITEDATA = r_mem_wdata;

   // The fill targets the latched miss address so a dropped CPU request cannot redirect it.
   assign w_fill_en = (r_state == ST_UPDATE) && !RESET;
   assign w_word_en = (r_state == ST_IDLE) && WRITE && !READ && w_hit && !RESET;
   assign w_wr_idx  = (r_state == ST_UPDATE) ? r_miss_addr[IDX_W-1:0] : w_idx;

   data_cache_line_array u_lines (
      .i_clk       (CLOCK),
      .i_rst       (RESET),
      .i_rd_idx    (w_idx),
      .o_valid     (w_valid),
      .o_dirty     (w_dirty),
      .o_tag       (w_line_tag),
      .o_data      (w_line_data),
      .i_wr_idx    (w_wr_idx),
      .i_fill_en   (w_fill_en),
      .i_fill_tag  (r_miss_addr[MEM_ADDR_W-1:IDX_W]),
      .i_fill_data (r_fill_data),
      .i_word_en   (w_word_en),
      .i_word_sel  (ADDRESS[3:2]),
      .i_word_data (WRITEDATA),
      .i_word_strb (WSTRB)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_miss_addr <= '0;
         r_fill_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_access && !w_hit) begin
                  r_miss_addr <= ADDRESS[31:4];
                  if (w_dirty) begin
                     r_state     <= ST_WRITEBACK;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= {w_line_tag, w_idx};
                     r_mem_wdata <= w_line_data;
                  end else begin
                     r_state    <= ST_FETCH;
                     r_mem_read <= 1'b1;
                     r_mem_addr <= ADDRESS[31:4];
                  end
               end
            end
            ST_WRITEBACK: begin
               // Hand straight over to the fetch so the request line never idles.
               if (!MEM_BUSYWAIT) begin
                  r_state     <= ST_FETCH;
                  r_mem_write <= 1'b0;
                  r_mem_read  <= 1'b1;
                  r_mem_addr  <= r_miss_addr;
               end
            end
            ST_FETCH: begin
               if (!MEM_BUSYWAIT) begin
                  r_state     <= ST_UPDATE;
                  r_mem_read  <= 1'b0;
                  r_fill_data <= MEM_READDATA;
               end
            end
            ST_UPDATE: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
      end
   end
endmodule
